// File: rtl/mem_arbiter.sv
// Purpose : two-master (icache/dcache) arbiter in front of a single-port RAM; dcache has priority, a streak limit prevents icache starvation.
// Latency : grant registered one cycle after the request; wait release is combinational with ram_ready; one DONE turnaround cycle follows.
// Backpressure: the loser's wait stays high; the winner's wait stays high until ram_ready, a timeout (err pulse) or its own abort.
// Ports   : CLK/RST (sync, active-high); iREN/iaddr -> iwait/iload; dREN/dWEN/daddr/dstore -> dwait/dload;
//           ramREN/ramWEN/ramaddr/ramstore -> RAM, ramload/ram_ready <- RAM; err = one-cycle timeout pulse.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic          iwait,
  output logic [DW-1:0] iload,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          dwait,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic          ram_ready,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] store_q, store_d;
  logic          err_q, err_d;

  logic d_req;
  logic win_req;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    store_d  = store_q;
    err_d    = 1'b0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    d_req    = dREN | dWEN;
    win_req  = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && ((streak_q < STREAK_MAX) || !iREN)) begin
          state_d = DGRANT;
          addr_d  = daddr;
          store_d = dstore;
          // A simultaneous read+write request is treated as a write.
          wen_d   = dWEN;
          ren_d   = !dWEN;
          timer_d = '0;
          // Streak only counts dcache wins that made a waiting icache lose.
          if (!iREN)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
        end else if (iREN) begin
          state_d  = IGRANT;
          addr_d   = iaddr;
          store_d  = dstore;
          ren_d    = 1'b1;
          wen_d    = 1'b0;
          timer_d  = '0;
          streak_d = '0;
        end
      end
      IGRANT, DGRANT: begin
        win_req = (state_q == IGRANT) ? iREN : d_req;
        if (ram_ready) begin
          if (state_q == IGRANT) begin
            iwait = 1'b0;
            iload = ramload;
          end else begin
            dwait = 1'b0;
            dload = wen_q ? '0 : ramload;
          end
          state_d = DONE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end else if (!win_req) begin
          // Winner walked away: abandon silently, no release, streak kept.
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      timer_q  <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      err_q    <= err_d;
    end
  end

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter with a transaction-level reference model.
// Latency : model predicts every cycle; directed tests pin key cycles with literal values.
// Backpressure: RAM readiness driven directly by the stimulus.
module tb_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO), .AW(32), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: who owns the RAM, how long it has held it, and
  // whether the post-transaction turnaround cycle is pending.
  int          m_owner;   // 0 = nobody, 1 = icache, 2 = dcache
  bit          m_live = 1'b0;
  bit          m_write, m_turn, m_err;
  int          m_age, m_streak;
  logic [31:0] m_addr, m_store;

  always @(posedge CLK) begin
    if (RST) begin
      m_live = 1'b1; m_owner = 0; m_turn = 1'b0; m_err = 1'b0;
      m_age = 0; m_streak = 0; m_addr = '0; m_store = '0; m_write = 1'b0;
    end else if (m_owner != 0) begin
      m_err = 1'b0;
      if (ram_ready) begin
        m_owner = 0; m_turn = 1'b1;
      end else if ((m_owner == 1 && !iREN) || (m_owner == 2 && !dREN && !dWEN)) begin
        m_owner = 0;
      end else if (m_age == TMO - 1) begin
        m_owner = 0; m_turn = 1'b1; m_err = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_turn) begin
      m_turn = 1'b0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if ((dREN || dWEN) && (m_streak < MAXS || !iREN)) begin
        m_owner = 2; m_write = dWEN; m_addr = daddr; m_store = dstore; m_age = 0;
        m_streak = iREN ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (iREN) begin
        m_owner = 1; m_write = 1'b0; m_addr = iaddr; m_store = dstore; m_age = 0;
        m_streak = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      logic rel_i, rel_d;
      rel_i = (m_owner == 1) && ram_ready;
      rel_d = (m_owner == 2) && ram_ready;
      check("m_ramREN", {31'b0, ramREN}, {31'b0, (m_owner == 1) || (m_owner == 2 && !m_write)});
      check("m_ramWEN", {31'b0, ramWEN}, {31'b0, (m_owner == 2) && m_write});
      check("m_ramaddr", ramaddr, m_addr);
      check("m_ramstore", ramstore, m_store);
      check("m_err", {31'b0, err}, {31'b0, m_err});
      check("m_iwait", {31'b0, iwait}, {31'b0, !rel_i});
      check("m_iload", iload, rel_i ? ramload : 32'h0);
      check("m_dwait", {31'b0, dwait}, {31'b0, !rel_d});
      check("m_dload", dload, (rel_d && !m_write) ? ramload : 32'h0);
    end
  end

  initial begin
    string seq;
    int    n;

    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ram_ready = 1'b0;

    // Reset held two cycles with both requests up.
    tick(); tick();
    check("rst_ramREN", {31'b0, ramREN}, 32'h0);
    check("rst_ramWEN", {31'b0, ramWEN}, 32'h0);
    check("rst_iwait", {31'b0, iwait}, 32'h1);
    check("rst_dwait", {31'b0, dwait}, 32'h1);
    check("rst_err", {31'b0, err}, 32'h0);
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0;
    tick();

    // Single icache read, RAM ready 3 cycles after grant.
    iREN = 1'b1; iaddr = 32'h40;
    tick();
    check("rd_ramREN", {31'b0, ramREN}, 32'h1);
    check("rd_ramaddr", ramaddr, 32'h40);
    tick(); tick();
    check("rd_iwait_hold", {31'b0, iwait}, 32'h1);
    ram_ready = 1'b1; ramload = 32'h2408000A;
    #1;
    check("rd_iwait_rel", {31'b0, iwait}, 32'h0);
    check("rd_iload", iload, 32'h2408000A);
    check("rd_dwait", {31'b0, dwait}, 32'h1);
    tick();
    ram_ready = 1'b0; iREN = 1'b0;
    #1;
    check("rd_iwait_once", {31'b0, iwait}, 32'h1);
    check("rd_strobe_drop", {31'b0, ramREN}, 32'h0);
    tick(); tick();

    // Simultaneous icache read and dcache write: dcache first.
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    tick();
    check("sim_ramWEN", {31'b0, ramWEN}, 32'h1);
    check("sim_ramREN", {31'b0, ramREN}, 32'h0);
    check("sim_ramstore", ramstore, 32'hDEADBEEF);
    check("sim_ramaddr", ramaddr, 32'h80);
    ram_ready = 1'b1; ramload = 32'h55555555;
    #1;
    check("sim_dwait", {31'b0, dwait}, 32'h0);
    check("sim_dload_wr", dload, 32'h0);
    check("sim_iwait_loser", {31'b0, iwait}, 32'h1);
    tick();
    ram_ready = 1'b0; dWEN = 1'b0;
    tick(); tick();
    check("sim_igrant", {31'b0, ramREN}, 32'h1);
    check("sim_iaddr", ramaddr, 32'h44);
    ram_ready = 1'b1; ramload = 32'h11111111;
    #1;
    check("sim_iload", iload, 32'h11111111);
    tick();
    ram_ready = 1'b0; iREN = 1'b0;
    tick(); tick();

    // Starvation guard: both requesting continuously, RAM always ready.
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h400; ram_ready = 1'b1;
    seq = "";
    for (int c = 0; c < 60 && seq.len() < 6; c++) begin
      ramload = 32'h1000 + c;
      #1;
      if (!dwait) seq = {seq, "D"};
      else if (!iwait) seq = {seq, "I"};
      tick();
    end
    n_checks++;
    if (seq != "DDDDID") begin
      n_fail++;
      $display("FAIL starve_seq: got %s expected DDDDID", seq);
    end
    iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
    tick(); tick(); tick();

    // Timeout: icache read never answered.
    iREN = 1'b1; iaddr = 32'h100;
    tick();
    n = 0;
    while (err !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 32'd8);
    check("tmo_ramREN", {31'b0, ramREN}, 32'h0);
    iREN = 1'b0;
    tick();
    check("tmo_err_pulse", {31'b0, err}, 32'h0);
    tick(); tick();

    // Abort: dcache read withdrawn on its second grant cycle.
    dREN = 1'b1; daddr = 32'h200;
    tick();
    check("abt_ramREN", {31'b0, ramREN}, 32'h1);
    tick();
    dREN = 1'b0;
    tick();
    check("abt_drop", {31'b0, ramREN}, 32'h0);
    check("abt_dwait", {31'b0, dwait}, 32'h1);
    tick();

    // Reset in the middle of a grant.
    iREN = 1'b1; iaddr = 32'h3C;
    tick();
    check("mrst_grant", {31'b0, ramREN}, 32'h1);
    RST = 1'b1;
    tick();
    check("mrst_ramREN", {31'b0, ramREN}, 32'h0);
    check("mrst_ramaddr", ramaddr, 32'h0);
    check("mrst_ramstore", ramstore, 32'h0);
    check("mrst_iwait", {31'b0, iwait}, 32'h1);
    check("mrst_err", {31'b0, err}, 32'h0);
    RST = 1'b0; iREN = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
